controlador_bcd: RTL and testbench



---
 rtl/controlador_bcd.sv | 82 ++++++++
 tb/tb_controlador_bcd.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/controlador_bcd.sv
// rtl/controlador_bcd.sv - sequential double-dabble binary-to-BCD converter feeding the display decoder
module controlador_bcd #(
  parameter int ANCHO   = 16,
  parameter int DIGITOS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inicio,
  input  logic [ANCHO-1:0]       numeroBinario,
  output logic [4*DIGITOS-1:0]   numeroBCD,
  output logic                   ocupado,
  output logic                   listo
);

  localparam int ANCHO_BCD  = 4 * DIGITOS;
  localparam int ANCHO_CONT = $clog2(ANCHO + 1);
  localparam logic [ANCHO_CONT-1:0] CUENTA_INICIAL = ANCHO_CONT'(ANCHO);
  localparam logic [ANCHO_CONT-1:0] CUENTA_UNO     = ANCHO_CONT'(1);

  localparam logic [1:0] REPOSO   = 2'd0;
  localparam logic [1:0] DESPLAZA = 2'd1;
  localparam logic [1:0] FIN      = 2'd2;

  logic [1:0]            estado;
  logic [ANCHO-1:0]      registroDesplazamiento;
  logic [ANCHO_BCD-1:0]  bcdParcial;
  logic [ANCHO_BCD-1:0]  bcdAjustado;
  logic [ANCHO_CONT-1:0] contador;

  // Add-3 correction per nibble; 4-bit arithmetic so carries stay inside the digit.
  always_comb begin
    bcdAjustado = bcdParcial;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcdParcial[4*i +: 4] >= 4'd5)
        bcdAjustado[4*i +: 4] = bcdParcial[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado                 <= REPOSO;
      registroDesplazamiento <= '0;
      bcdParcial             <= '0;
      contador               <= '0;
      numeroBCD              <= '0;
      ocupado                <= 1'b0;
      listo                  <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          listo <= 1'b0;
          if (inicio) begin
            registroDesplazamiento <= numeroBinario;
            bcdParcial             <= '0;
            contador               <= CUENTA_INICIAL;
            ocupado                <= 1'b1;
            estado                 <= DESPLAZA;
          end
        end
        DESPLAZA: begin
          // The whole pair shifts as one word; the scratch MSB falls off the top.
          {bcdParcial, registroDesplazamiento} <= {bcdAjustado, registroDesplazamiento} << 1;
          contador <= contador - CUENTA_UNO;
          if (contador == CUENTA_UNO)
            estado <= FIN;
        end
        FIN: begin
          numeroBCD <= bcdParcial;
          listo     <= 1'b1;
          ocupado   <= 1'b0;
          estado    <= REPOSO;
        end
        default: begin
          ocupado <= 1'b0;
          listo   <= 1'b0;
          estado  <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_bcd.sv
// tb/tb_controlador_bcd.sv - directed self-checking bench for controlador_bcd
module tb_controlador_bcd;

  logic        clk;
  logic        rst;
  logic        inicio;
  logic [15:0] numeroBinario;
  logic [19:0] numeroBCD;
  logic        ocupado;
  logic        listo;

  int numAsserts = 0;
  int numFails   = 0;
  logic [19:0] bcdPrevio;

  controlador_bcd #(.ANCHO(16), .DIGITOS(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .inicio        (inicio),
    .numeroBinario (numeroBinario),
    .numeroBCD     (numeroBCD),
    .ocupado       (ocupado),
    .listo         (listo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numAsserts++;
    assert (obs === exp) else begin
      numFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepting edge k, busy through k+16, result and listo at k+17, listo low at k+18.
  task automatic convertir(input logic [15:0] valor, input logic [19:0] esperado, input string tag);
    numeroBinario = valor;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    check({tag, " ocupado@k"}, {31'd0, ocupado}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (ocupado !== 1'b1 || listo !== 1'b0 || numeroBCD !== bcdPrevio)
        check({tag, " busy-window"}, {11'd0, ocupado, listo, numeroBCD}, {11'd0, 1'b1, 1'b0, bcdPrevio});
    end
    tick();
    check({tag, " resultado"}, {12'd0, numeroBCD}, {12'd0, esperado});
    check({tag, " listo"}, {31'd0, listo}, 32'd1);
    check({tag, " ocupado-fin"}, {31'd0, ocupado}, 32'd0);
    tick();
    check({tag, " listo-pulso"}, {31'd0, listo}, 32'd0);
    bcdPrevio = esperado;
  endtask

  initial begin
    rst = 1'b1;
    inicio = 1'b0;
    numeroBinario = '0;
    bcdPrevio = '0;
    tick();
    tick();
    check("reset numeroBCD", {12'd0, numeroBCD}, 32'h0);
    check("reset ocupado", {31'd0, ocupado}, 32'd0);
    check("reset listo", {31'd0, listo}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("idle ocupado", {31'd0, ocupado}, 32'd0);

    convertir(16'd12345, 20'h12345, "v12345");

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("async rst numeroBCD", {12'd0, numeroBCD}, 32'h0);
    check("async rst ocupado", {31'd0, ocupado}, 32'd0);
    check("async rst listo", {31'd0, listo}, 32'd0);
    tick();
    rst = 1'b0;
    bcdPrevio = '0;
    tick();

    convertir(16'd65535, 20'h65535, "v65535");
    convertir(16'd0,     20'h00000, "v0");
    convertir(16'd9,     20'h00009, "v9");
    convertir(16'd10,    20'h00010, "v10");
    convertir(16'd1000,  20'h01000, "v1000");

    // Ignore inicio and operand changes while busy.
    numeroBinario = 16'd4321;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin
        inicio = 1'b1;
        numeroBinario = 16'd777;
      end
      tick();
      inicio = 1'b0;
      if (numeroBCD !== bcdPrevio || listo !== 1'b0)
        check("busy hold", {11'd0, listo, numeroBCD}, {11'd0, 1'b0, bcdPrevio});
    end
    tick();
    check("busy resultado", {12'd0, numeroBCD}, 32'h04321);
    check("busy listo", {31'd0, listo}, 32'd1);
    tick();
    check("busy listo-pulso", {31'd0, listo}, 32'd0);
    check("busy no-requeue", {31'd0, ocupado}, 32'd0);
    bcdPrevio = 20'h04321;

    // Reset mid-conversion.
    convertir(16'd42, 20'h00042, "v42");
    numeroBinario = 16'd500;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    check("mid pre-rst hold", {12'd0, numeroBCD}, 32'h00042);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst numeroBCD", {12'd0, numeroBCD}, 32'h0);
    check("mid rst ocupado", {31'd0, ocupado}, 32'd0);
    tick();
    rst = 1'b0;
    bcdPrevio = '0;
    for (int i = 0; i < 20; i++) tick();
    check("post-rst idle ocupado", {31'd0, ocupado}, 32'd0);
    check("post-rst idle listo", {31'd0, listo}, 32'd0);
    convertir(16'd500, 20'h00500, "v500");

    // Back-to-back with inicio held high.
    numeroBinario = 16'd250;
    inicio = 1'b1;
    tick();
    numeroBinario = 16'd31;
    for (int i = 1; i <= 16; i++) tick();
    tick();
    check("b2b first resultado", {12'd0, numeroBCD}, 32'h00250);
    check("b2b first listo", {31'd0, listo}, 32'd1);
    tick();
    inicio = 1'b0;
    check("b2b reaccept ocupado", {31'd0, ocupado}, 32'd1);
    check("b2b reaccept listo", {31'd0, listo}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (listo !== 1'b0 || numeroBCD !== 20'h00250)
        check("b2b second hold", {11'd0, listo, numeroBCD}, {11'd0, 1'b0, 20'h00250});
    end
    tick();
    check("b2b second resultado", {12'd0, numeroBCD}, 32'h00031);
    check("b2b second listo", {31'd0, listo}, 32'd1);
    tick();
    check("b2b second listo-pulso", {31'd0, listo}, 32'd0);
    check("b2b idle ocupado", {31'd0, ocupado}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
